// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: FSM states,
// alu opcodes used for the Booth steps, and iteration sizing.
package multdiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; the most negative value maps to 2^31 unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/alu.sv
// Execute-stage 32-bit alu: add, sub, and, or, sll, sra with signed
// overflow and compare flags.
module alu (
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;

    assign sum     = data_operandA + data_operandB;
    assign diff    = data_operandA - data_operandB;
    assign add_ovf = (data_operandA[31] == data_operandB[31]) && (sum[31] != data_operandA[31]);
    assign sub_ovf = (data_operandA[31] != data_operandB[31]) && (diff[31] != data_operandA[31]);

    always_comb begin
        data_result = sum;
        overflow    = 1'b0;
        case (ctrl_ALUopcode)
            5'b00000: begin data_result = sum;  overflow = add_ovf; end
            5'b00001: begin data_result = diff; overflow = sub_ovf; end
            5'b00010: data_result = data_operandA & data_operandB;
            5'b00011: data_result = data_operandA | data_operandB;
            5'b00100: data_result = data_operandA << ctrl_shiftamt;
            5'b00101: data_result = $signed(data_operandA) >>> ctrl_shiftamt;
            default:  data_result = sum;
        endcase
    end

    assign isNotEqual = (data_operandA != data_operandB);
    assign isLessThan = diff[31] ^ sub_ovf;

endmodule

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift the next dividend bit into
// the remainder, subtract the divisor when it fits, and shift in the quotient bit.
module div_step
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor});
    // When the divisor fits the true difference is below 2^32, so the modulo result is exact.
    assign trial    = shifted[WIDTH-1:0] - divisor;
    assign rem_next = fits ? trial : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply (radix-2 Booth through the alu) and
// restoring divide; 32 iterations per operation, one-cycle result pulse.
module multdiv_seq
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output state_t           dbg_state
);
    // Handshake: ctrl_MULT/ctrl_DIV are single-cycle requests, accepted only in
    // IDLE or DONE (MULT wins a tie); data_resultRDY is a one-cycle valid with no
    // back-pressure, and data_result/data_exception hold until the next DONE.
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             start_ok;
    logic             start_mult;
    logic             start_div;
    logic             last_iter;

    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             div_zero;
    logic             div_ovf;

    assign start_ok   = (ctrl_MULT || ctrl_DIV) && (state == ST_IDLE || state == ST_DONE);
    assign start_mult = start_ok && ctrl_MULT;
    assign start_div  = start_ok && !ctrl_MULT;
    assign last_iter  = (cnt == CNT_W'(ITER));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_mult)     state_nxt = ST_MULT;
                else if (start_div) state_nxt = ST_DIV;
                else                state_nxt = ST_IDLE;
            end
            ST_MULT: if (last_iter) state_nxt = ST_DONE;
            ST_DIV:  if (div_zero || last_iter) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Booth step: alu does P+/-M; the true 33-bit sign is recovered from the
    // add/sub overflow so P never loses its sign, even for M = 0x80000000.
    logic [1:0]       booth;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_ne_unused;
    logic             alu_lt_unused;
    logic             alu_ovf_unused;
    logic [WIDTH-1:0] p_sel;
    logic             p_sign;
    logic             step_ovf;

    assign booth  = {q_reg[0], q_1};
    assign alu_op = (booth == 2'b10) ? ALU_SUB : ALU_ADD;

    alu u_alu (
        .data_operandA  (p_reg),
        .data_operandB  (m_reg),
        .ctrl_ALUopcode (alu_op),
        .ctrl_shiftamt  (5'd0),
        .data_result    (alu_sum),
        .isNotEqual     (alu_ne_unused),
        .isLessThan     (alu_lt_unused),
        .overflow       (alu_ovf_unused)
    );

    always_comb begin
        p_sel    = p_reg;
        step_ovf = 1'b0;
        p_sign   = p_reg[WIDTH-1];
        if (booth == 2'b10) begin
            p_sel    = alu_sum;
            step_ovf = (p_reg[WIDTH-1] != m_reg[WIDTH-1]) && (alu_sum[WIDTH-1] != p_reg[WIDTH-1]);
            p_sign   = alu_sum[WIDTH-1] ^ step_ovf;
        end else if (booth == 2'b01) begin
            p_sel    = alu_sum;
            step_ovf = (p_reg[WIDTH-1] == m_reg[WIDTH-1]) && (alu_sum[WIDTH-1] != p_reg[WIDTH-1]);
            p_sign   = alu_sum[WIDTH-1] ^ step_ovf;
        end
    end

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    div_step u_div_step (
        .rem      (rem),
        .quo      (q_reg),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            p_reg          <= '0;
            q_reg          <= '0;
            q_1            <= 1'b0;
            m_reg          <= '0;
            rem            <= '0;
            dvsr           <= '0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            if (start_mult) begin
                cnt   <= '0;
                p_reg <= '0;
                q_reg <= data_operandA;
                q_1   <= 1'b0;
                m_reg <= data_operandB;
            end else if (start_div) begin
                cnt      <= '0;
                rem      <= '0;
                q_reg    <= mag(data_operandA);
                dvsr     <= mag(data_operandB);
                neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
            end else if (state == ST_MULT && !last_iter) begin
                cnt   <= cnt + CNT_W'(1);
                p_reg <= {p_sign, p_sel[WIDTH-1:1]};
                q_reg <= {p_sel[0], q_reg[WIDTH-1:1]};
                q_1   <= q_reg[0];
            end else if (state == ST_DIV && !last_iter && !div_zero) begin
                cnt   <= cnt + CNT_W'(1);
                rem   <= rem_next;
                q_reg <= quo_next;
            end

            if (state == ST_MULT && state_nxt == ST_DONE) begin
                data_result    <= q_reg;
                data_exception <= (p_reg != {WIDTH{q_reg[WIDTH-1]}});
            end else if (state == ST_DIV && state_nxt == ST_DONE) begin
                data_result    <= div_zero ? '0 : (neg_q ? -q_reg : q_reg);
                data_exception <= div_zero || div_ovf;
            end
        end
    end

    assign data_resultRDY = (state == ST_DONE);
    assign busy           = (state == ST_MULT) || (state == ST_DIV);
    assign dbg_state      = state;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: the driver pushes model results into a
// queue, a negedge monitor pops and compares on every data_resultRDY.
module tb_multdiv_seq;
    import multdiv_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    state_t      dbg_state;

    multdiv_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // {exception, result}, and the expected edges from the start edge to RDY
    logic [32:0] exp_q[$];
    int          lat_q[$];
    int unsigned start_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: plain signed arithmetic
    task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        longint prod;
        int     sa;
        int     sb;
        if (is_mult) begin
            prod = longint'($signed(a)) * longint'($signed(b));
            res  = prod[31:0];
            exc  = (prod != longint'($signed(res)));
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            sa  = $signed(a);
            sb  = $signed(b);
            res = sa / sb;
            exc = 1'b0;
        end
    endtask

    // driver: called at a negedge; the pulse is sampled at the next posedge
    task automatic issue(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        model(is_mult, a, b, r, e);
        exp_q.push_back({e, r});
        lat_q.push_back((!is_mult && b == 32'd0) ? 1 : 33);
        start_q.push_back(cyc + 1);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = is_mult;
        ctrl_DIV      = !is_mult;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (exp_q.size() == 0) done = 1'b1;
            else @(negedge clock);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
            start_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic run(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        issue(is_mult, a, b);
        wait_drain();
    endtask

    // monitor / scoreboard
    logic [31:0] held_res = '0;
    logic        held_exc = 1'b0;
    logic        prev_rdy = 1'b0;

    always @(negedge clock) begin
        logic [32:0] e;
        int          l;
        int unsigned s;
        if (!reset_n) begin
            held_res = '0;
            held_exc = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (data_resultRDY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rdy actual=1 required=0 at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    s = start_q.pop_front();
                    chk("result", 64'(data_result), 64'(e[31:0]));
                    chk("exception", 64'(data_exception), 64'(e[32]));
                    chk("latency", 64'(cyc - s), 64'(l));
                    chk("busy_at_rdy", 64'(busy), 64'd0);
                    chk("rdy_single", 64'(prev_rdy), 64'd0);
                    held_res = e[31:0];
                    held_exc = e[32];
                end
            end else begin
                chk("hold_result", 64'(data_result), 64'(held_res));
                chk("hold_exception", 64'(data_exception), 64'(held_exc));
            end
            prev_rdy = data_resultRDY;
        end
    end

    logic [31:0] ra;
    logic [31:0] rb;
    bit          found;

    initial begin
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset_result", 64'(data_result), 64'd0);
        chk("reset_exception", 64'(data_exception), 64'd0);
        chk("reset_rdy", 64'(data_resultRDY), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clock);

        // directed arithmetic and boundaries
        run(1'b1, 32'd7, 32'hFFFF_FFFD);
        run(1'b1, 32'h4000_0000, 32'd4);
        run(1'b1, 32'h8000_0000, 32'd1);
        run(1'b1, 32'd12345, 32'h8000_0000);
        run(1'b0, 32'hFFFF_FFF9, 32'd2);
        run(1'b0, 32'd100, 32'hFFFF_FFF9);
        run(1'b0, 32'd5, 32'd0);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 32'h8000_0000, 32'd1);

        // both starts high: multiply wins
        model(1'b1, 32'd9, 32'd6, ra[31:0], found);
        exp_q.push_back({found, ra});
        lat_q.push_back(33);
        start_q.push_back(cyc + 1);
        data_operandA = 32'd9;
        data_operandB = 32'd6;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        wait_drain();

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($signed($urandom_range(0, 60000)) - 30000);
            run(i[0], ra, rb);
        end

        // a divide pulse during multiply iteration 10 is ignored
        issue(1'b1, 32'h0001_2345, 32'hFFFF_0F0F);
        repeat (9) @(negedge clock);
        chk("busy_mid_op", 64'(busy), 64'd1);
        data_operandA = 32'd77;
        data_operandB = 32'd0;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_drain();

        // start in the RDY cycle is accepted back-to-back
        issue(1'b0, 32'd1000, 32'd7);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (data_resultRDY) found = 1'b1;
        end
        chk("b2b_rdy_seen", 64'(found), 64'd1);
        issue(1'b1, 32'hFFFF_FF00, 32'd300);
        wait_drain();

        // reset mid-divide aborts with no RDY
        issue(1'b0, 32'h7FFF_FFFF, 32'd3);
        repeat (14) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_result", 64'(data_result), 64'd0);
        chk("abort_exception", 64'(data_exception), 64'd0);
        chk("abort_rdy", 64'(data_resultRDY), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.delete();
        lat_q.delete();
        start_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        run(1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFF6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
